// File: rtl/dma_cfg_sequencer.sv
// Captures a four-word DMA descriptor on start, writes it over the register bus
// (io, mem, intr, control), optionally reads each word back and flags the first mismatch.
module dma_cfg_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic [DATA_WIDTH-1:0] cfg_intr,
  input  logic [DATA_WIDTH-1:0] cfg_control,
  input  logic [DATA_WIDTH-1:0] cfg_io_addr,
  input  logic [DATA_WIDTH-1:0] cfg_mem_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_idx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, WR, RD_REQ, RD_WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            idx, idx_n;
  logic [DATA_WIDTH-1:0] desc [4];
  logic                  verify_q;
  logic                  cap;
  logic                  busy_n, done_n, err_n, wr_en_n, valid_n;
  logic [1:0]            err_idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  // Control goes last because writing it arms the DMA.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [1:0] i);
    case (i)
      2'd0:    beat_addr = BASE_ADDR + ADDR_WIDTH'(8);
      2'd1:    beat_addr = BASE_ADDR + ADDR_WIDTH'(12);
      2'd2:    beat_addr = BASE_ADDR;
      default: beat_addr = BASE_ADDR + ADDR_WIDTH'(4);
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cap       = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = err;
    err_idx_n = err_idx;
    addr_n    = addr;
    wr_en_n   = wr_en;
    valid_n   = 1'b0;
    wdata_n   = wdata;
    case (state)
      IDLE: begin
        if (start) begin
          cap       = 1'b1;
          err_n     = 1'b0;
          err_idx_n = 2'd0;
          state_n   = LOAD;
        end
      end
      LOAD: begin
        state_n = WR;
        idx_n   = 2'd0;
        busy_n  = 1'b1;
        valid_n = 1'b1;
        wr_en_n = 1'b1;
        addr_n  = beat_addr(2'd0);
        wdata_n = desc[0];
      end
      WR: begin
        if (idx == 2'd3) begin
          idx_n = 2'd0;
          if (verify_q) begin
            state_n = RD_REQ;
            valid_n = 1'b1;
            wr_en_n = 1'b0;
            addr_n  = beat_addr(2'd0);
          end else begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          idx_n   = idx + 2'd1;
          valid_n = 1'b1;
          wr_en_n = 1'b1;
          addr_n  = beat_addr(idx + 2'd1);
          wdata_n = desc[idx + 2'd1];
        end
      end
      RD_REQ: state_n = RD_WAIT;
      RD_WAIT: begin
        if (rdata != desc[idx]) begin
          err_n     = 1'b1;
          err_idx_n = idx;
          state_n   = DONE;
          busy_n    = 1'b0;
          done_n    = 1'b1;
        end else if (idx == 2'd3) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + 2'd1;
          state_n = RD_REQ;
          valid_n = 1'b1;
          wr_en_n = 1'b0;
          addr_n  = beat_addr(idx + 2'd1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 2'd0;
      verify_q <= 1'b0;
      for (int i = 0; i < 4; i++) desc[i] <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= 2'd0;
      addr     <= '0;
      wr_en    <= 1'b0;
      valid    <= 1'b0;
      wdata    <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      if (cap) begin
        verify_q <= verify_en;
        desc[0]  <= cfg_io_addr;
        desc[1]  <= cfg_mem_addr;
        desc[2]  <= cfg_intr;
        desc[3]  <= cfg_control;
      end
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_idx  <= err_idx_n;
      addr     <= addr_n;
      wr_en    <= wr_en_n;
      valid    <= valid_n;
      wdata    <= wdata_n;
    end
  end

endmodule
